// File: rtl/neosd_card_cmd_fsm_if.sv
// ============================================================================
// Module   : neosd_card_cmd_fsm_if
// Brief    : Command hand-off bus between the SD CMD responder and the
//            card-emulation logic that supplies response parameters.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface neosd_card_cmd_fsm_if;
  logic         cmd_valid_o;
  logic [5:0]   cmd_idx_o;
  logic [31:0]  cmd_arg_o;
  logic         cmd_err_o;
  logic         busy_o;
  logic         cmd_ack_i;
  logic [1:0]   resp_mode_i;
  logic [5:0]   resp_idx_i;
  logic [127:0] resp_data_i;

  // Responder side: presents received commands, consumes response parameters.
  modport slave (
    output cmd_valid_o, cmd_idx_o, cmd_arg_o, cmd_err_o, busy_o,
    input  cmd_ack_i, resp_mode_i, resp_idx_i, resp_data_i
  );

  // Card-emulation side.
  modport master (
    input  cmd_valid_o, cmd_idx_o, cmd_arg_o, cmd_err_o, busy_o,
    output cmd_ack_i, resp_mode_i, resp_idx_i, resp_data_i
  );
endinterface

`default_nettype wire

// File: rtl/neosd_card_cmd_fsm.sv
// ============================================================================
// Module   : neosd_card_cmd_fsm
// Brief    : Card-side SD CMD line engine: receives/validates 48-bit host
//            commands and serialises short or long (R2) responses after Ncr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module neosd_card_cmd_fsm #(
  parameter int NCR = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clkstrb_i,
  input  logic sd_cmd_i,
  output logic sd_cmd_o,
  output logic sd_cmd_oe,
  neosd_card_cmd_fsm_if.slave cmd_if
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RECV     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_NCR      = 3'd3,
    ST_SEND     = 3'd4
  } state_t;

  localparam logic [7:0] NCR_LAST   = 8'(NCR - 1);
  localparam logic [7:0] LEN_SHORT  = 8'd48;
  localparam logic [7:0] LEN_LONG   = 8'd136;

  state_t       state_q;
  logic [7:0]   cnt_q;
  logic [45:0]  rx_q;
  logic [6:0]   crc_q;
  logic [135:0] tx_q;
  logic         long_q;
  logic         valid_q;
  logic [5:0]   idx_q;
  logic [31:0]  arg_q;
  logic         err_q;
  logic         oe_q;
  logic         out_q;

  logic [46:0]  rx_frame_d;
  logic         frame_ok_d;
  logic [135:0] tx_d;
  logic [7:0]   len_d;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // Bits 46..0 of the incoming frame once the end bit is on the line.
  assign rx_frame_d = {rx_q, sd_cmd_i};
  assign frame_ok_d = rx_frame_d[46] && (rx_frame_d[7:1] == crc_q) && rx_frame_d[0];
  assign len_d      = long_q ? LEN_LONG : LEN_SHORT;

  // Short frames splice the running CRC and the end bit in after 40 payload bits.
  always_comb begin
    tx_d = {tx_q[134:0], 1'b0};
    if (!long_q && (cnt_q == 8'd40)) begin
      tx_d[135:128] = {crc_q, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      crc_q   <= '0;
      tx_q    <= '0;
      long_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      arg_q   <= '0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
      out_q   <= 1'b1;
    end else if (clkstrb_i) begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!sd_cmd_i) begin
            state_q <= ST_RECV;
            cnt_q   <= 8'd1;
            rx_q    <= '0;
            crc_q   <= crc7_step(7'd0, sd_cmd_i);
          end
        end

        ST_RECV: begin
          rx_q  <= rx_frame_d[45:0];
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q <= 8'd39) begin
            crc_q <= crc7_step(crc_q, sd_cmd_i);
          end
          if (cnt_q == 8'd47) begin
            if (frame_ok_d) begin
              idx_q   <= rx_frame_d[45:40];
              arg_q   <= rx_frame_d[39:8];
              valid_q <= 1'b1;
              state_q <= ST_WAIT_ACK;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end

        ST_WAIT_ACK: begin
          if (cmd_if.cmd_ack_i) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            long_q  <= (cmd_if.resp_mode_i == 2'd2);
            if (cmd_if.resp_mode_i == 2'd2) begin
              tx_q <= {2'b00, 6'h3F, cmd_if.resp_data_i};
            end else begin
              tx_q <= {2'b00, cmd_if.resp_idx_i, cmd_if.resp_data_i[31:0], 96'd0};
            end
            if ((cmd_if.resp_mode_i == 2'd1) || (cmd_if.resp_mode_i == 2'd2)) begin
              state_q <= ST_NCR;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_NCR: begin
          if (cnt_q == NCR_LAST) begin
            state_q <= ST_SEND;
            oe_q    <= 1'b1;
            out_q   <= tx_q[135];
            crc_q   <= crc7_step(7'd0, tx_q[135]);
            cnt_q   <= 8'd1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        ST_SEND: begin
          if (cnt_q == len_d) begin
            oe_q    <= 1'b0;
            out_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tx_q  <= tx_d;
            out_q <= tx_d[135];
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q < 8'd40) begin
              crc_q <= crc7_step(crc_q, tx_d[135]);
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sd_cmd_o           = out_q;
  assign sd_cmd_oe          = oe_q;
  assign cmd_if.cmd_valid_o = valid_q;
  assign cmd_if.cmd_idx_o   = idx_q;
  assign cmd_if.cmd_arg_o   = arg_q;
  assign cmd_if.cmd_err_o   = err_q;
  assign cmd_if.busy_o      = (state_q != ST_IDLE);

endmodule

`default_nettype wire
